// File: rtl/vga_sync_gen_if.sv
// Raster timing bus between the VGA sync generator and the pixel pipeline.
// The master side supplies the pixel strobe; the slave side returns timing.
interface vga_sync_gen_if;
  logic       pix_en;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       frame_start;

  modport master (
    output pix_en,
    input  hsync, vsync, video_on, pix_x, pix_y, frame_start
  );

  modport slave (
    input  pix_en,
    output hsync, vsync, video_on, pix_x, pix_y, frame_start
  );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel/line counters advanced by pix_en, with
// sync, visible-area and start-of-frame flags decoded from the next count.
module vga_sync_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input logic            clk,
  input logic            clr_n,
  vga_sync_gen_if.slave  vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  // 11-bit bounds so a limit of exactly 1024 does not wrap to zero.
  localparam logic [10:0] H_VIS_END = 11'(H_VISIBLE);
  localparam logic [10:0] H_SYN_BEG = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] H_SYN_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_VIS_END = 11'(V_VISIBLE);
  localparam logic [10:0] V_SYN_BEG = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] V_SYN_END = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       video_on_q, video_on_d;
  logic       frame_start_q, frame_start_d;

  logic        h_wrap, v_wrap;
  logic [9:0]  h_nxt, v_nxt;
  logic [10:0] h_nxt_w, v_nxt_w;

  always_comb begin
    h_wrap  = (h_cnt_q == H_LAST);
    v_wrap  = (v_cnt_q == V_LAST);
    h_nxt   = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
    v_nxt   = h_wrap ? (v_wrap ? 10'd0 : v_cnt_q + 10'd1) : v_cnt_q;
    h_nxt_w = {1'b0, h_nxt};
    v_nxt_w = {1'b0, v_nxt};

    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    video_on_d    = video_on_q;
    frame_start_d = 1'b0;

    // Flags decode the count being loaded so they stay aligned with pix_x/pix_y.
    if (vga.pix_en) begin
      h_cnt_d       = h_nxt;
      v_cnt_d       = v_nxt;
      hsync_d       = ((h_nxt_w >= H_SYN_BEG) && (h_nxt_w < H_SYN_END)) ? SYNC_POL : ~SYNC_POL;
      vsync_d       = ((v_nxt_w >= V_SYN_BEG) && (v_nxt_w < V_SYN_END)) ? SYNC_POL : ~SYNC_POL;
      video_on_d    = (h_nxt_w < H_VIS_END) && (v_nxt_w < V_VIS_END);
      frame_start_d = h_wrap && v_wrap;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      h_cnt_q       <= 10'd0;
      v_cnt_q       <= 10'd0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      video_on_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga.pix_x       = h_cnt_q;
  assign vga.pix_y       = v_cnt_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.video_on    = video_on_q;
  assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default 640x480 timing on one instance, and a tiny raster
// (16x13, active-high sync) for whole-frame behaviour within a short run.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic clr_n = 1'b0;
  always #5 clk = ~clk;

  vga_sync_gen_if bus_d ();
  vga_sync_gen_if bus_s ();

  vga_sync_gen u_dut_d (
    .clk   (clk),
    .clr_n (clr_n),
    .vga   (bus_d)
  );

  vga_sync_gen #(
    .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (3),
    .V_VISIBLE (6), .V_FRONT (2), .V_SYNC (2), .V_BACK (3),
    .SYNC_POL  (1'b1)
  ) u_dut_s (
    .clk   (clk),
    .clr_n (clr_n),
    .vga   (bus_s)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  // Default instance: one pix_en every 4th clk.
  task automatic strobe_d(input int n);
    for (int i = 0; i < n; i++) begin
      bus_d.pix_en = 1'b1;
      clk1();
      bus_d.pix_en = 1'b0;
      repeat (3) clk1();
    end
  endtask

  initial begin
    int ex, ey, errs, fs_seen, last_fs, period, vs_cnt, vis_cnt;
    logic exp_fs, exp_hs, exp_vs, exp_vid;

    bus_d.pix_en = 1'b0;
    bus_s.pix_en = 1'b0;
    clr_n = 1'b0;
    repeat (6) begin
      bus_d.pix_en = ~bus_d.pix_en;
      bus_s.pix_en = ~bus_s.pix_en;
      clk1();
    end
    chk("rst_hsync", bus_d.hsync, 1);
    chk("rst_vsync", bus_d.vsync, 1);
    chk("rst_video", bus_d.video_on, 0);
    chk("rst_x", bus_d.pix_x, 0);
    chk("rst_y", bus_d.pix_y, 0);
    chk("rst_fs", bus_d.frame_start, 0);
    chk("rst_s_hsync", bus_s.hsync, 0);
    chk("rst_s_vsync", bus_s.vsync, 0);

    bus_d.pix_en = 1'b0;
    bus_s.pix_en = 1'b0;
    #2 clr_n = 1'b1;
    clk1();
    chk("rel_video", bus_d.video_on, 0);
    strobe_d(1);
    chk("first_x", bus_d.pix_x, 1);
    chk("first_video", bus_d.video_on, 1);

    strobe_d(638);
    chk("x639", bus_d.pix_x, 639);
    chk("x639_video", bus_d.video_on, 1);
    strobe_d(1);
    chk("x640_video", bus_d.video_on, 0);
    strobe_d(15);
    chk("x655_hsync", bus_d.hsync, 1);
    strobe_d(1);
    chk("x656", bus_d.pix_x, 656);
    chk("x656_hsync", bus_d.hsync, 0);

    strobe_d(44);
    bus_d.pix_en = 1'b0;
    repeat (50) clk1();
    chk("stall_x", bus_d.pix_x, 700);
    chk("stall_y", bus_d.pix_y, 0);
    chk("stall_hsync", bus_d.hsync, 0);
    chk("stall_vsync", bus_d.vsync, 1);
    chk("stall_video", bus_d.video_on, 0);
    chk("stall_fs", bus_d.frame_start, 0);
    strobe_d(1);
    chk("resume_x", bus_d.pix_x, 701);

    strobe_d(50);
    chk("x751_hsync", bus_d.hsync, 0);
    strobe_d(1);
    chk("x752_hsync", bus_d.hsync, 1);
    strobe_d(47);
    chk("x799", bus_d.pix_x, 799);
    chk("x799_y", bus_d.pix_y, 0);
    strobe_d(1);
    chk("hwrap_x", bus_d.pix_x, 0);
    chk("hwrap_y", bus_d.pix_y, 1);
    chk("hwrap_video", bus_d.video_on, 1);
    chk("hwrap_fs", bus_d.frame_start, 0);

    // Back-to-back strobes advance every clk.
    bus_d.pix_en = 1'b1;
    repeat (300) clk1();
    bus_d.pix_en = 1'b0;
    chk("b2b_x", bus_d.pix_x, 300);
    chk("b2b_y", bus_d.pix_y, 1);

    // Small raster, two full frames of consecutive strobes against a model.
    ex = 0; ey = 0; errs = 0; fs_seen = 0; last_fs = -1; period = 0;
    vs_cnt = 0; vis_cnt = 0;
    bus_s.pix_en = 1'b1;
    for (int i = 0; i < 416; i++) begin
      clk1();
      exp_fs = (ex == 15) && (ey == 12);
      if (ex == 15) begin
        ex = 0;
        ey = (ey == 12) ? 0 : ey + 1;
      end else begin
        ex = ex + 1;
      end
      exp_hs  = (ex >= 10) && (ex < 13);
      exp_vs  = (ey >= 8) && (ey < 10);
      exp_vid = (ex < 8) && (ey < 6);
      if (bus_s.pix_x !== 10'(ex) || bus_s.pix_y !== 10'(ey) ||
          bus_s.hsync !== exp_hs || bus_s.vsync !== exp_vs ||
          bus_s.video_on !== exp_vid || bus_s.frame_start !== exp_fs)
        errs++;
      if (bus_s.frame_start === 1'b1) begin
        fs_seen++;
        if (last_fs >= 0) period = i - last_fs;
        last_fs = i;
      end
      if (i >= 208) begin
        if (bus_s.vsync === 1'b1) vs_cnt++;
        if (bus_s.video_on === 1'b1) vis_cnt++;
      end
    end
    chk("sm_pixel_errs", errs, 0);
    chk("sm_fs_count", fs_seen, 2);
    chk("sm_frame_period", period, 208);
    chk("sm_vsync_strobes", vs_cnt, 32);
    chk("sm_visible_strobes", vis_cnt, 48);

    bus_s.pix_en = 1'b0;
    clk1();
    chk("sm_fs_width", bus_s.frame_start, 0);
    chk("sm_hold_x", bus_s.pix_x, 0);
    chk("sm_hold_y", bus_s.pix_y, 0);
    chk("sm_origin_video", bus_s.video_on, 1);

    bus_s.pix_en = 1'b1;
    repeat (53) clk1();
    bus_s.pix_en = 1'b0;
    chk("sm_pre_rst_x", bus_s.pix_x, 5);
    chk("sm_pre_rst_y", bus_s.pix_y, 3);

    // Asynchronous mid-frame reset, checked before the next rising edge.
    #2 clr_n = 1'b0;
    #1;
    chk("mrst_x", bus_d.pix_x, 0);
    chk("mrst_y", bus_d.pix_y, 0);
    chk("mrst_hsync", bus_d.hsync, 1);
    chk("mrst_vsync", bus_d.vsync, 1);
    chk("mrst_video", bus_d.video_on, 0);
    chk("mrst_s_x", bus_s.pix_x, 0);
    chk("mrst_s_y", bus_s.pix_y, 0);
    chk("mrst_s_video", bus_s.video_on, 0);
    bus_d.pix_en = 1'b1;
    bus_s.pix_en = 1'b1;
    errs = 0;
    repeat (5) begin
      clk1();
      if (bus_d.frame_start !== 1'b0 || bus_s.frame_start !== 1'b0 ||
          bus_d.pix_x !== 10'd0) errs++;
    end
    chk("mrst_hold", errs, 0);
    bus_d.pix_en = 1'b0;
    bus_s.pix_en = 1'b0;
    #2 clr_n = 1'b1;
    clk1();
    chk("mrst_rel_fs", bus_d.frame_start, 0);
    chk("mrst_rel_x", bus_d.pix_x, 0);
    strobe_d(1);
    chk("mrst_resume_x", bus_d.pix_x, 1);
    chk("mrst_resume_y", bus_d.pix_y, 0);
    chk("mrst_resume_video", bus_d.video_on, 1);
    chk("mrst_resume_fs", bus_d.frame_start, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
